// File: rtl/output_store_validate_iq_if.sv
// I/Q sample stream interface: filtered input side plus FIFO drain handshake.
// master drives samples and out_ready; slave (the store stage) drives out_*.
interface output_store_validate_iq_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
);
    logic [IN_W-1:0]  i_in;
    logic [IN_W-1:0]  q_in;
    logic             in_valid;
    logic [OUT_W-1:0] out_i;
    logic [OUT_W-1:0] out_q;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output i_in, q_in, in_valid, out_ready,
        input  out_i, out_q, out_valid
    );

    modport slave (
        input  i_in, q_in, in_valid, out_ready,
        output out_i, out_q, out_valid
    );
endinterface

// File: rtl/output_store_validate_iq.sv
// I/Q output store: decimate, narrow (round/saturate), buffer in show-ahead FIFO.
// Ports: clk, rst (sync, high), bus (I/Q stream), rate, round_en, clr_flags,
// fill (occupancy), overflow and sat_flag (sticky status).
module output_store_validate_iq #(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 10,
    parameter int DEPTH  = 16,
    parameter int RATE_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    output_store_validate_iq_if.slave bus,
    input  logic [RATE_W-1:0]        rate,
    input  logic                     round_en,
    input  logic                     clr_flags,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic                     sat_flag
);
    localparam int S  = IN_W - OUT_W;
    localparam int AW = $clog2(DEPTH);

    logic [RATE_W-1:0] phase_q, phase_d;
    logic              accept;

    logic [OUT_W-1:0]  i_nar, q_nar;
    logic              i_sat, q_sat;

    logic              stg_vld_q, stg_vld_d;
    logic [OUT_W-1:0]  stg_i_q, stg_i_d;
    logic [OUT_W-1:0]  stg_q_q, stg_q_d;

    logic [2*OUT_W-1:0] mem_q [DEPTH];
    logic [2*OUT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        fill_q, fill_d;
    logic               ovf_q, ovf_d;
    logic               sat_q, sat_d;

    logic full, empty, pop, push, drop;

    // Decimation: live compare against rate so a lowered rate wraps at once.
    always_comb begin
        phase_d = phase_q;
        if (bus.in_valid) begin
            if (rate <= RATE_W'(1) || phase_q >= rate - RATE_W'(1))
                phase_d = '0;
            else
                phase_d = phase_q + RATE_W'(1);
        end
    end

    assign accept = bus.in_valid && (phase_q == '0);

    if (S == 0) begin : g_pass
        assign i_nar = bus.i_in;
        assign q_nar = bus.q_in;
        assign i_sat = 1'b0;
        assign q_sat = 1'b0;
    end else begin : g_nar
        // Returns {sat, value}. One guard bit catches the rounding carry;
        // only positive overflow is possible, so clamp to max positive.
        function automatic logic [OUT_W:0] narrow(
            input logic [IN_W-1:0] x,
            input logic            rnd
        );
            logic [IN_W:0]  ext;
            logic [OUT_W:0] sh;
            ext = {x[IN_W-1], x};
            if (rnd)
                ext = ext + (IN_W+1)'(1 << (S - 1));
            sh = ext[IN_W:S];
            if (sh[OUT_W] != sh[OUT_W-1])
                narrow = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
            else
                narrow = {1'b0, sh[OUT_W-1:0]};
        endfunction

        assign {i_sat, i_nar} = narrow(bus.i_in, round_en);
        assign {q_sat, q_nar} = narrow(bus.q_in, round_en);
    end

    always_comb begin
        stg_vld_d = accept;
        stg_i_d   = stg_i_q;
        stg_q_d   = stg_q_q;
        if (accept) begin
            stg_i_d = i_nar;
            stg_q_d = q_nar;
        end
    end

    assign full  = (fill_q == (AW+1)'(DEPTH));
    assign empty = (fill_q == '0);
    assign pop   = !empty && bus.out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still push.
    assign push  = stg_vld_q && (!full || pop);
    assign drop  = stg_vld_q && full && !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            mem_d[wr_ptr_q] = {stg_i_q, stg_q_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)
            fill_d = fill_q + (AW+1)'(1);
        else if (pop && !push)
            fill_d = fill_q - (AW+1)'(1);
    end

    // Set events take priority over clear.
    always_comb begin
        ovf_d = drop || (ovf_q && !clr_flags);
        sat_d = (accept && (i_sat || q_sat)) || (sat_q && !clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= '0;
            stg_vld_q <= 1'b0;
            stg_i_q   <= '0;
            stg_q_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            stg_vld_q <= stg_vld_d;
            stg_i_q   <= stg_i_d;
            stg_q_q   <= stg_q_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid = !empty;
    assign bus.out_i     = empty ? '0 : mem_q[rd_ptr_q][2*OUT_W-1:OUT_W];
    assign bus.out_q     = empty ? '0 : mem_q[rd_ptr_q][OUT_W-1:0];
    assign fill          = fill_q;
    assign overflow      = ovf_q;
    assign sat_flag      = sat_q;
endmodule

// File: tb/tb_output_store_validate_iq.sv
// Self-checking bench for output_store_validate_iq (DEPTH=4 instance).
// Directed vector table for narrowing plus hand-written multi-cycle sequences.
module tb_output_store_validate_iq;
    localparam int IN_W   = 12;
    localparam int OUT_W  = 10;
    localparam int DEPTH  = 4;
    localparam int RATE_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [RATE_W-1:0] rate;
    logic              round_en;
    logic              clr_flags;
    logic [2:0]        fill;
    logic              overflow;
    logic              sat_flag;

    int checks   = 0;
    int failures = 0;

    output_store_validate_iq_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    output_store_validate_iq #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .RATE_W(RATE_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .rate(rate),
        .round_en(round_en), .clr_flags(clr_flags),
        .fill(fill), .overflow(overflow), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  i;
        logic [IN_W-1:0]  q;
        logic             rnd;
        logic [OUT_W-1:0] ei;
        logic [OUT_W-1:0] eq;
        logic             es;
    } vec_t;

    vec_t vt [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{12'hAAA, 12'h555, 1'b0, 10'h2AA, 10'h155, 1'b0};
        vt[1] = '{12'hAAA, 12'h555, 1'b1, 10'h2AB, 10'h155, 1'b0};
        vt[2] = '{12'h7FF, 12'h800, 1'b1, 10'h1FF, 10'h200, 1'b1};
        vt[3] = '{12'h7FF, 12'h7FC, 1'b0, 10'h1FF, 10'h1FF, 1'b0};
        vt[4] = '{12'h7FE, 12'h001, 1'b1, 10'h1FF, 10'h000, 1'b1};
        vt[5] = '{12'h7FD, 12'hFFF, 1'b1, 10'h1FF, 10'h000, 1'b0};
        vt[6] = '{12'hFFE, 12'h802, 1'b0, 10'h3FF, 10'h200, 1'b0};

        bus.i_in = '0;
        bus.q_in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        rate = 9'd1;
        round_en = 1'b0;
        clr_flags = 1'b0;

        // Reset state, with in_valid asserted during reset
        bus.in_valid = 1'b1;
        bus.i_in = 12'h100;
        do_reset();
        bus.in_valid = 1'b0;
        chk("rst_fill", fill, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_out_i", bus.out_i, 0);
        chk("rst_out_q", bus.out_q, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sat", sat_flag, 0);
        tick();
        chk("rst_ignored_in", fill, 0);

        // out_ready while empty has no effect
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("empty_pop_fill", fill, 0);
        chk("empty_pop_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Narrowing vector table: latency, values, sat, then drain + clear
        for (int n = 0; n < 7; n++) begin
            round_en = vt[n].rnd;
            bus.i_in = vt[n].i;
            bus.q_in = vt[n].q;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_lat1", n), bus.out_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", n), bus.out_valid, 1);
            chk($sformatf("v%0d_out_i", n), bus.out_i, vt[n].ei);
            chk($sformatf("v%0d_out_q", n), bus.out_q, vt[n].eq);
            chk($sformatf("v%0d_sat", n), sat_flag, vt[n].es);
            bus.out_ready = 1'b1;
            clr_flags = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            clr_flags = 1'b0;
            chk($sformatf("v%0d_clr", n), sat_flag, 0);
            chk($sformatf("v%0d_drain", n), bus.out_valid, 0);
        end

        // Set wins over clear in the same cycle
        round_en = 1'b1;
        bus.i_in = 12'h7FF;
        bus.q_in = 12'h000;
        bus.in_valid = 1'b1;
        clr_flags = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        clr_flags = 1'b0;
        chk("set_wins_sat", sat_flag, 1);
        tick();
        chk("set_wins_val", bus.out_i, 10'h1FF);
        bus.out_ready = 1'b1;
        clr_flags = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        clr_flags = 1'b0;
        chk("sat_cleared", sat_flag, 0);
        round_en = 1'b0;

        // Decimation rate=4, i_in=4k, k=0..11
        do_reset();
        rate = 9'd4;
        bus.q_in = '0;
        for (int k = 0; k < 12; k++) begin
            bus.i_in = IN_W'(4 * k);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("dec_fill", fill, 3);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("dec_out%0d", j), bus.out_i, 4 * j);
            tick();
        end
        bus.out_ready = 1'b0;
        chk("dec_empty", bus.out_valid, 0);

        // Mid-operation reset with fill=3, phase=2
        for (int k = 0; k < 10; k++) begin
            bus.i_in = IN_W'(4 * k + 4);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mrst_pre_fill", fill, 3);
        chk("mrst_pre_head", bus.out_i, 1);
        bus.in_valid = 1'b1;
        bus.i_in = 12'd100;
        do_reset();
        bus.in_valid = 1'b0;
        chk("mrst_fill", fill, 0);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_out_i", bus.out_i, 0);
        chk("mrst_out_q", bus.out_q, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_sat", sat_flag, 0);
        bus.i_in = 12'd40;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mrst_first_fill", fill, 1);
        chk("mrst_first_val", bus.out_i, 10);

        // Overflow: six pairs into DEPTH=4 with no drain
        do_reset();
        rate = 9'd1;
        for (int k = 1; k <= 6; k++) begin
            bus.i_in = IN_W'(4 * k);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("ovf_fill", fill, 4);
        chk("ovf_flag", overflow, 1);
        bus.out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("ovf_valid%0d", j), bus.out_valid, 1);
            chk($sformatf("ovf_out%0d", j), bus.out_i, j);
            tick();
        end
        bus.out_ready = 1'b0;
        chk("ovf_drained", bus.out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Concurrent push/pop on a full FIFO, continuous input
        for (int k = 1; k <= 4; k++) begin
            bus.i_in = IN_W'(4 * k);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("cc_full", fill, 4);
        bus.i_in = 12'd20;
        bus.in_valid = 1'b1;
        tick();
        bus.i_in = 12'd24;
        bus.out_ready = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("cc_out%0d", j), bus.out_i, j + 2);
            chk($sformatf("cc_fill%0d", j), fill, 4);
            chk($sformatf("cc_ovf%0d", j), overflow, 0);
            bus.i_in = IN_W'(4 * (7 + j));
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_store_validate_iq.md
Name: output_store_validate_iq

Overview:
Dual-channel (I/Q) successor to the single-channel output storage/validation stage at the tail of the QAM modulator filter chain. It decimates filtered samples by a runtime rate, converts them from filter width to DAC width with optional rounding and saturation, and buffers I/Q pairs in a FIFO. The FIFO drains through a valid/ready handshake and reports sticky overflow and saturation status.

Parameters:
IN_W, 12, signed filter sample width per channel
OUT_W, 10, signed output sample width per channel; must satisfy OUT_W <= IN_W
DEPTH, 16, FIFO depth in I/Q pairs; power of 2, >= 2
RATE_W, 9, width of decimation-rate input

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
i_in  in  IN_W  I sample, two's complement
q_in  in  IN_W  Q sample, two's complement
in_valid  in  1  i_in/q_in valid this cycle
rate  in  RATE_W  decimation factor N; 0 and 1 both mean keep every sample
round_en  in  1  1 = round-half-up before narrowing; 0 = truncate (floor)
clr_flags  in  1  clears sticky flags
out_i  out  OUT_W  FIFO head I value; 0 when empty
out_q  out  OUT_W  FIFO head Q value; 0 when empty
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid=1
fill  out  log2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a pair was dropped because the FIFO was full
sat_flag  out  1  sticky: rounding overflowed and the value was clamped

Behaviour:
- Reset: all outputs 0. Phase counter, stage register, FIFO pointers and flags are cleared. in_valid is ignored in the reset cycle. A mid-operation reset discards all buffered data.
- Decimation:
  - phase counter advances only on in_valid.
  - A sample is accepted when in_valid=1 and phase==0.
  - Next phase is 0 if phase >= rate-1 (or rate<=1); otherwise phase+1.
  - rate is compared live, so lowering rate mid-count wraps on the next in_valid.
- Narrowing, per channel, with S = IN_W-OUT_W:
  - round_en=1 and S>0: add 2^(S-1), then arithmetic shift right by S.
  - round_en=0: arithmetic shift right by S only.
  - If the rounded result exceeds the OUT_W positive range, clamp to 2^(OUT_W-1)-1 and set sat_flag.
  - Negative overflow cannot occur. S=0 is pass-through.
- Pipeline:
  - An accepted pair is registered into the stage at edge N.
  - It is written to the FIFO at edge N+1.
  - out_valid rises after edge N+1, i.e. 2-cycle latency into an empty FIFO.
- FIFO: show-ahead; out_i/out_q always present the head entry.
  - Pop on out_valid & out_ready.
  - Write when stage valid and (not full, or pop in the same cycle).
  - Full with no pop: the stage pair is dropped and overflow is set. The pair already stored is unaffected.
  - Simultaneous push and pop leaves fill unchanged.
  - out_ready while empty has no effect.
  - Pointers wrap modulo DEPTH.
- Flags: sticky until rst or clr_flags. If a set event and clr_flags occur in the same cycle, set wins (flag reads 1).
- fill is registered and reflects post-edge occupancy.

Test Plan:
- Truncation, round_en=0, rate=1: i_in=12'hAAA, q_in=12'h555 -> out_i=10'h2AA, out_q=10'h155, out_valid 2 cycles after accept, sat_flag=0.
- Rounding, round_en=1: i_in=12'hAAA -> out_i=10'h2AB. i_in=12'h7FF -> out_i=10'h1FF and sat_flag=1. clr_flags pulse -> sat_flag=0.
- Decimation, rate=4, in_valid held high, i_in=4*k for k=0..11 -> FIFO holds out_i = 0, 4, 8 (inputs 0, 16, 32); fill=3.
- Overflow, DEPTH=4, out_ready=0, rate=1, six pairs i_in=4,8,...,24 -> fill=4, overflow=1. Then out_ready=1 drains out_i=1, 2, 3, 4 in order; out_valid falls after 4 pops.
- Concurrent push/pop, FIFO full, out_ready=1, continuous input -> fill stays 4, overflow stays 0, output sequence has no gaps.
- Mid-operation reset: rst for 1 cycle while fill=3 and phase=2 -> next cycle fill=0, out_valid=0, outputs 0, flags 0. The first post-reset in_valid is accepted (phase=0).
